occupancy_counter: RTL and testbench
====================================

Name: occupancy_counter

Overview:
Parametrised two-sensor bidirectional occupancy counter for the doorway board design. It conditions two sensor/button inputs (A = outer, B = inner) and decodes the entry sequence A, AB, B, none and the exit sequence B, AB, A, none. It maintains a saturating occupancy count with FULL/EMPTY flags and event pulses. It drives the board LEDs directly and replaces the fixed 4-bit entry/exit counter top.

Parameters:
CNT_W, 4, occupancy count width in bits
MAX_COUNT, 15, capacity limit; must be ≤ 2^CNT_W-1 and ≥ 1
SYNC_STAGES, 2, synchroniser flops per sensor input (≥ 2)
DEB_CYCLES, 4, consecutive stable cycles required before a filtered sensor changes (≥ 1)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
SENS_A  in  1  outer sensor (board BTN1), asynchronous, active-high
SENS_B  in  1  inner sensor (board BTN4), asynchronous, active-high
COUNT  out  CNT_W  current occupancy
FULL  out  1  COUNT == MAX_COUNT
EMPTY  out  1  COUNT == 0
ENTRY_PULSE  out  1  one-cycle pulse on a counted entry
EXIT_PULSE  out  1  one-cycle pulse on a counted exit
SEQ_ERR  out  1  one-cycle pulse on an illegal sensor transition
ALARM  out  1  capacity alarm (optional feature)

Behaviour:
- One clock. Reset is synchronous and active-high on RST. All state is cleared on CLK edges with RST=1.
- Reset values: COUNT=0, EMPTY=1, FULL=0, all pulses 0, ALARM=0, FSM=IDLE, synchronisers and filtered sensors 0, debounce counters 0.
- Conditioning per sensor: SYNC_STAGES-flop synchroniser, then debounce. The filtered value changes only after the synchronised value differs from it for DEB_CYCLES consecutive cycles. Any mismatch-free cycle clears the counter. Filter latency from pin edge = SYNC_STAGES + DEB_CYCLES cycles.
- The FSM operates on the filtered pair {a,b}. A pair unchanged from the previous cycle holds the current state.
- FSM states and transitions:
  - IDLE: 10 goes to EN1; 01 goes to EX1; 11 goes to WAIT_IDLE with SEQ_ERR.
  - EN1 (10): 11 goes to EN2; 00 goes to IDLE (abort, no error); 01 goes to WAIT_IDLE with SEQ_ERR.
  - EN2 (11): 01 goes to EN3; 10 goes to EN1 (backtrack); 00 goes to WAIT_IDLE with SEQ_ERR.
  - EN3 (01): 00 completes an entry and returns to IDLE; 11 goes to EN2 (backtrack); 10 goes to WAIT_IDLE with SEQ_ERR.
  - EX1, EX2, EX3 mirror EN1–EN3 with the roles of a and b swapped. 00 from EX3 completes an exit.
  - WAIT_IDLE: stays until the pair is 00, then goes to IDLE. Nothing is counted in this state.
- Entry completion:
  - If COUNT < MAX_COUNT: COUNT+1 and ENTRY_PULSE=1.
  - Else: COUNT is held, no pulse, rejected-entry flag raised (see ALARM).
- Exit completion:
  - If COUNT > 0: COUNT-1 and EXIT_PULSE=1.
  - Else: COUNT is held, no pulse.
- Timing of completion: COUNT, FULL and EMPTY update and the pulse asserts in the cycle after the FSM observes 00. Total latency from final pin release = SYNC_STAGES + DEB_CYCLES + 1 cycles.
- Count arithmetic is unsigned CNT_W bits and never wraps. FULL and EMPTY are registered and consistent with COUNT in every cycle.
- Only one completion can occur per cycle, so there are no simultaneous entry/exit events.
- RST mid-sequence aborts the sequence. Nothing is counted, and COUNT returns to 0.
- If sensors are still active after reset, a filtered 11 from IDLE gives SEQ_ERR and WAIT_IDLE.

Optional Feature:
OCC_CAPACITY_ALARM_EN
- Defined: ALARM sets in the cycle a completed entry is rejected because FULL=1. It stays set until the next counted exit or RST.
- Undefined: ALARM is tied to 0 and no alarm logic is synthesised.

Decomposition:
- Package occ_pkg: FSM state encoding (IDLE, EN1–EN3, EX1–EX3, WAIT_IDLE; 3-bit) and sensor-pair constants (P_NONE=00, P_A=10, P_B=01, P_AB=11).
- Sub-module sensor_debounce (parameters SYNC_STAGES, DEB_CYCLES; ports CLK, RST, IN, OUT), instantiated once per sensor. The FSM and counter stay in occupancy_counter.

Test Plan:
- Defaults. Seven full entry sequences, each pair held 10 cycles -> COUNT 1..7, seven ENTRY_PULSEs, EMPTY=0, no SEQ_ERR. Then seven exit sequences -> COUNT back to 0, seven EXIT_PULSEs, EMPTY=1.
- MAX_COUNT=3. Four entries -> COUNT saturates at 3, FULL=1, exactly three ENTRY_PULSEs. With OCC_CAPACITY_ALARM_EN, ALARM=1 after the fourth entry; one exit -> COUNT=2, ALARM=0.
- COUNT=0, one exit sequence -> COUNT stays 0, no EXIT_PULSE, EMPTY=1.
- Glitch handling. A 2-cycle pulse on SENS_A (shorter than DEB_CYCLES=4) -> FSM stays IDLE, no pulses. Sequence 10, 11, 10, 00 (backtrack, abort) -> COUNT unchanged, no SEQ_ERR.
- Illegal transitions. Pair 00 to 11 directly -> one SEQ_ERR pulse; subsequent 01 then 00 is not counted; a following valid entry counts normally. 10 to 01 directly -> SEQ_ERR.
- COUNT=5 with a sequence paused in EN2, assert RST for 1 cycle -> COUNT=0, EMPTY=1, FSM=IDLE. Releasing the still-pressed sensors -> no count and no spurious pulse.

Source files
------------

// File: rtl/occ_pkg.sv
// Shared types for the doorway occupancy counter: FSM state encoding
// and the filtered sensor-pair codes {a,b}.
package occ_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EN1,
    S_EN2,
    S_EN3,
    S_EX1,
    S_EX2,
    S_EX3,
    S_WAIT
  } occ_state_e;

  localparam logic [1:0] P_NONE = 2'b00;
  localparam logic [1:0] P_A    = 2'b10;
  localparam logic [1:0] P_B    = 2'b01;
  localparam logic [1:0] P_AB   = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// Synchroniser plus debounce filter for one asynchronous sensor pin.
// OUT follows IN only after DEB_CYCLES consecutive differing cycles.
module sensor_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic IN,
  output logic OUT
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   filt_q, filt_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], IN};
    filt_d = filt_q;
    cnt_d  = '0;
    // a single agreeing cycle restarts the run
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        filt_d = ~filt_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign OUT = filt_q;

endmodule

// File: rtl/occupancy_counter.sv
// Two-sensor doorway occupancy counter with saturating count and flags.
// Define OCC_CAPACITY_ALARM_EN to build the rejected-entry ALARM latch.
module occupancy_counter
  import occ_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int MAX_COUNT   = 15,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SENS_A,
  input  logic             SENS_B,
  output logic [CNT_W-1:0] COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ENTRY_PULSE,
  output logic             EXIT_PULSE,
  output logic             SEQ_ERR,
  output logic             ALARM
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

  logic       a_f, b_f;
  logic [1:0] pair;

  sensor_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_a (
    .CLK(CLK),
    .RST(RST),
    .IN (SENS_A),
    .OUT(a_f)
  );

  sensor_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb_b (
    .CLK(CLK),
    .RST(RST),
    .IN (SENS_B),
    .OUT(b_f)
  );

  assign pair = {a_f, b_f};

  occ_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ent_q, ent_d;
  logic             ext_q, ext_d;
  logic             err_q, err_d;
  logic             ent_done, ext_done;

  always_comb begin
    state_d  = state_q;
    err_d    = 1'b0;
    ent_done = 1'b0;
    ext_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        case (pair)
          P_A:     state_d = S_EN1;
          P_B:     state_d = S_EX1;
          P_AB:    begin state_d = S_WAIT; err_d = 1'b1; end
          default: ;
        endcase
      end
      S_EN1: begin
        case (pair)
          P_AB:    state_d = S_EN2;
          P_NONE:  state_d = S_IDLE;
          P_B:     begin state_d = S_WAIT; err_d = 1'b1; end
          default: ;
        endcase
      end
      S_EN2: begin
        case (pair)
          P_B:     state_d = S_EN3;
          P_A:     state_d = S_EN1;
          P_NONE:  begin state_d = S_WAIT; err_d = 1'b1; end
          default: ;
        endcase
      end
      S_EN3: begin
        case (pair)
          P_NONE:  begin state_d = S_IDLE; ent_done = 1'b1; end
          P_AB:    state_d = S_EN2;
          P_A:     begin state_d = S_WAIT; err_d = 1'b1; end
          default: ;
        endcase
      end
      S_EX1: begin
        case (pair)
          P_AB:    state_d = S_EX2;
          P_NONE:  state_d = S_IDLE;
          P_A:     begin state_d = S_WAIT; err_d = 1'b1; end
          default: ;
        endcase
      end
      S_EX2: begin
        case (pair)
          P_A:     state_d = S_EX3;
          P_B:     state_d = S_EX1;
          P_NONE:  begin state_d = S_WAIT; err_d = 1'b1; end
          default: ;
        endcase
      end
      S_EX3: begin
        case (pair)
          P_NONE:  begin state_d = S_IDLE; ext_done = 1'b1; end
          P_AB:    state_d = S_EX2;
          P_B:     begin state_d = S_WAIT; err_d = 1'b1; end
          default: ;
        endcase
      end
      S_WAIT: begin
        if (pair == P_NONE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    ent_d   = 1'b0;
    ext_d   = 1'b0;
    if (ent_done && !full_q) begin
      count_d = count_q + CNT_W'(1);
      ent_d   = 1'b1;
    end
    if (ext_done && !empty_q) begin
      count_d = count_q - CNT_W'(1);
      ext_d   = 1'b1;
    end
    full_d  = (count_d == CNT_MAX);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ent_q   <= 1'b0;
      ext_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ent_q   <= ent_d;
      ext_q   <= ext_d;
      err_q   <= err_d;
    end
  end

`ifdef OCC_CAPACITY_ALARM_EN
  logic alarm_q, alarm_d;

  // latches on a rejected entry, released only by a counted exit
  always_comb begin
    alarm_d = alarm_q;
    if (ext_d) alarm_d = 1'b0;
    if (ent_done && full_q) alarm_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) alarm_q <= 1'b0;
    else     alarm_q <= alarm_d;
  end

  assign ALARM = alarm_q;
`else
  assign ALARM = 1'b0;
`endif

  assign COUNT       = count_q;
  assign FULL        = full_q;
  assign EMPTY       = empty_q;
  assign ENTRY_PULSE = ent_q;
  assign EXIT_PULSE  = ext_q;
  assign SEQ_ERR     = err_q;

endmodule

// File: tb/tb_occupancy_counter.sv
// Bench for occupancy_counter: default instance and a MAX_COUNT=3 instance
// share the sensors; table, hand sequences and a random walk vs. a model.
module tb_occupancy_counter;

  logic clk = 1'b0;
  logic rst, sa, sb;
  always #5 clk = ~clk;

  logic [3:0] cnt_w [2];
  logic full_w [2], empty_w [2], ent_w [2], ext_w [2], err_w [2], alm_w [2];

  occupancy_counter u_dut0 (
    .CLK(clk), .RST(rst), .SENS_A(sa), .SENS_B(sb),
    .COUNT(cnt_w[0]), .FULL(full_w[0]), .EMPTY(empty_w[0]),
    .ENTRY_PULSE(ent_w[0]), .EXIT_PULSE(ext_w[0]),
    .SEQ_ERR(err_w[0]), .ALARM(alm_w[0])
  );

  occupancy_counter #(.MAX_COUNT(3)) u_dut1 (
    .CLK(clk), .RST(rst), .SENS_A(sa), .SENS_B(sb),
    .COUNT(cnt_w[1]), .FULL(full_w[1]), .EMPTY(empty_w[1]),
    .ENTRY_PULSE(ent_w[1]), .EXIT_PULSE(ext_w[1]),
    .SEQ_ERR(err_w[1]), .ALARM(alm_w[1])
  );

  int ent_n [2], ext_n [2], err_n [2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ent_w[d]) ent_n[d] += 1;
      if (ext_w[d]) ext_n[d] += 1;
      if (err_w[d]) err_n[d] += 1;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int d, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // model: position along the entry/exit path, counts per instance
  int mdir, mpos;
  logic [1:0] mprev;
  int mcnt [2], malarm [2];
  int mmax [2] = '{15, 3};
  int dent [2], dext [2], derr [2];

  task automatic model_reset();
    mdir = 0; mpos = 0; mprev = 2'b00;
    for (int d = 0; d < 2; d++) begin mcnt[d] = 0; malarm[d] = 0; end
  endtask

  task automatic model_pair(input logic [1:0] p, output int ev);
    logic [1:0] path [3];
    int j;
    ev = 0;
    if (p == mprev) return;
    mprev = p;
    case (mdir)
      3: if (p == 2'b00) mdir = 0;
      0: begin
        if (p == 2'b10) begin mdir = 1; mpos = 0; end
        else if (p == 2'b01) begin mdir = 2; mpos = 0; end
        else begin mdir = 3; ev = 3; end
      end
      default: begin
        if (mdir == 1) path = '{2'b10, 2'b11, 2'b01};
        else path = '{2'b01, 2'b11, 2'b10};
        if (p == 2'b00) begin
          if (mpos == 2) begin ev = mdir; mdir = 0; end
          else if (mpos == 0) mdir = 0;
          else begin mdir = 3; ev = 3; end
        end else begin
          j = 0;
          for (int k = 0; k < 3; k++) if (path[k] == p) j = k;
          if (j == mpos + 1 || j == mpos - 1) mpos = j;
          else begin mdir = 3; ev = 3; end
        end
      end
    endcase
  endtask

  task automatic step(input logic [1:0] p, input int hold, input int glitch);
    int ev, xe, xx, xr, xa;
    int e0 [2], x0 [2], r0 [2];
    for (int d = 0; d < 2; d++) begin
      e0[d] = ent_n[d]; x0[d] = ext_n[d]; r0[d] = err_n[d];
    end
    @(negedge clk);
    sa = p[1]; sb = p[0];
    repeat (hold) @(negedge clk);
    if (glitch > 0) begin
      sa = ~p[1];
      repeat (glitch) @(negedge clk);
      sa = p[1];
      repeat (6) @(negedge clk);
    end
    model_pair(p, ev);
    for (int d = 0; d < 2; d++) begin
      xe = 0; xx = 0; xr = (ev == 3) ? 1 : 0;
      if (ev == 1) begin
        if (mcnt[d] < mmax[d]) begin mcnt[d]++; xe = 1; end
        else malarm[d] = 1;
      end
      if (ev == 2 && mcnt[d] > 0) begin
        mcnt[d]--; xx = 1; malarm[d] = 0;
      end
`ifdef OCC_CAPACITY_ALARM_EN
      xa = malarm[d];
`else
      xa = 0;
`endif
      dent[d] = ent_n[d] - e0[d];
      dext[d] = ext_n[d] - x0[d];
      derr[d] = err_n[d] - r0[d];
      chk("count", d, int'(cnt_w[d]), mcnt[d]);
      chk("full", d, int'(full_w[d]), (mcnt[d] == mmax[d]) ? 1 : 0);
      chk("empty", d, int'(empty_w[d]), (mcnt[d] == 0) ? 1 : 0);
      chk("alarm", d, int'(alm_w[d]), xa);
      chk("entry_pulses", d, dent[d], xe);
      chk("exit_pulses", d, dext[d], xx);
      chk("seq_err_pulses", d, derr[d], xr);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [1:0] p;
    int c0, c1, e0, e1, x0, x1, er, al;
  } vec_t;
  vec_t tbl [$];
  int tc0, tc1, tal;

  task automatic add(input logic [1:0] p, input int e0, input int e1,
                     input int x0, input int x1, input int er);
    vec_t v;
    v.p = p; v.c0 = tc0; v.c1 = tc1;
    v.e0 = e0; v.e1 = e1; v.x0 = x0; v.x1 = x1; v.er = er; v.al = tal;
    tbl.push_back(v);
  endtask

  task automatic add_entry();
    int e0, e1;
    add(2'b10, 0, 0, 0, 0, 0);
    add(2'b11, 0, 0, 0, 0, 0);
    add(2'b01, 0, 0, 0, 0, 0);
    e0 = (tc0 < 15) ? 1 : 0; tc0 += e0;
    e1 = (tc1 < 3) ? 1 : 0; tc1 += e1;
    if (e1 == 0) tal = 1;
    add(2'b00, e0, e1, 0, 0, 0);
  endtask

  task automatic add_exit();
    int x0, x1;
    add(2'b01, 0, 0, 0, 0, 0);
    add(2'b11, 0, 0, 0, 0, 0);
    add(2'b10, 0, 0, 0, 0, 0);
    x0 = (tc0 > 0) ? 1 : 0; tc0 -= x0;
    x1 = (tc1 > 0) ? 1 : 0; tc1 -= x1;
    if (x1 == 1) tal = 0;
    add(2'b00, 0, 0, x0, x1, 0);
  endtask

  logic [1:0] ring [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  initial begin
    int s0, ci, r, g, xa;
    logic [1:0] p, cur;
    rst = 1'b1; sa = 1'b0; sb = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("rst_count", d, int'(cnt_w[d]), 0);
      chk("rst_empty", d, int'(empty_w[d]), 1);
      chk("rst_full", d, int'(full_w[d]), 0);
      chk("rst_pulses", d, int'({ent_w[d], ext_w[d], err_w[d]}), 0);
      chk("rst_alarm", d, int'(alm_w[d]), 0);
    end

    tc0 = 0; tc1 = 0; tal = 0;
    for (int k = 0; k < 7; k++) add_entry();
    for (int k = 0; k < 7; k++) add_exit();
    add_exit();
    add(2'b10, 0, 0, 0, 0, 0); add(2'b11, 0, 0, 0, 0, 0);
    add(2'b10, 0, 0, 0, 0, 0); add(2'b00, 0, 0, 0, 0, 0);
    add(2'b11, 0, 0, 0, 0, 1); add(2'b01, 0, 0, 0, 0, 0);
    add(2'b00, 0, 0, 0, 0, 0);
    add_entry();
    add(2'b10, 0, 0, 0, 0, 0); add(2'b01, 0, 0, 0, 0, 1);
    add(2'b00, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) add_entry();
    add_exit();

    foreach (tbl[i]) begin
      step(tbl[i].p, 10, 0);
      chk("tbl_count", 0, int'(cnt_w[0]), tbl[i].c0);
      chk("tbl_count", 1, int'(cnt_w[1]), tbl[i].c1);
      chk("tbl_entry", 0, dent[0], tbl[i].e0);
      chk("tbl_entry", 1, dent[1], tbl[i].e1);
      chk("tbl_exit", 0, dext[0], tbl[i].x0);
      chk("tbl_exit", 1, dext[1], tbl[i].x1);
      chk("tbl_seq_err", 0, derr[0], tbl[i].er);
`ifdef OCC_CAPACITY_ALARM_EN
      xa = tbl[i].al;
`else
      xa = 0;
`endif
      chk("tbl_alarm", 1, int'(alm_w[1]), xa);
    end

    // short pulse on A must be swallowed by the filter
    s0 = ent_n[0] + ext_n[0] + err_n[0];
    @(negedge clk); sa = 1'b1;
    repeat (2) @(negedge clk); sa = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_pulses", 0, ent_n[0] + ext_n[0] + err_n[0] - s0, 0);
    chk("glitch_count", 0, int'(cnt_w[0]), 3);
    step(2'b10, 10, 0); step(2'b11, 10, 0);
    step(2'b01, 10, 0); step(2'b00, 10, 0);
    chk("post_glitch_entry", 0, dent[0], 1);
    chk("post_glitch_count", 0, int'(cnt_w[0]), 4);

    // reset while paused in EN2 with sensors held
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(2'b10, 10, 0); step(2'b11, 10, 0);
      step(2'b01, 10, 0); step(2'b00, 10, 0);
    end
    chk("pre_rst_count", 0, int'(cnt_w[0]), 5);
    step(2'b10, 10, 0); step(2'b11, 10, 0);
    do_reset();
    chk("mid_rst_count", 0, int'(cnt_w[0]), 0);
    chk("mid_rst_empty", 0, int'(empty_w[0]), 1);
    step(2'b11, 10, 0);
    chk("held_after_rst_err", 0, derr[0], 1);
    step(2'b01, 10, 0); step(2'b00, 10, 0);
    chk("released_count", 0, int'(cnt_w[0]), 0);
    chk("released_entry", 0, dent[0], 0);

    ci = 0; cur = 2'b00;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 7);
      if (r == 0) begin
        p = 2'($urandom_range(0, 3));
        for (int k = 0; k < 4; k++) if (ring[k] == p) ci = k;
      end else begin
        ci = (r <= 4) ? (ci + 1) % 4 : (ci + 3) % 4;
        p = ring[ci];
      end
      g = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      step(p, $urandom_range(10, 14), g);
      cur = p;
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
        step(cur, 10, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
